enc_cnt_capture: RTL and testbench

- Downstream consumer of the dual-channel encoder counter (ENC_TOP).
- Snapshots each channel's 64-bit count on every rising edge of that channel's A-output strobe, tags it with channel id and per-channel sequence number, and buffers records in a FIFO.
- Serialises each record as a 32-bit valid/ready word stream toward the DAQ readout/DMA path.

---
 rtl/enc_cnt_capture.sv | 208 ++++++++++++++++++++
 tb/tb_enc_cnt_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_cnt_capture.sv
`default_nettype none
// ------------------------------------------------------------------------
// enc_cnt_capture : per-channel count capture on strobe edges, record FIFO
// and 32-bit record serialiser. Optional macro: ENC_CAP_TIMESTAMP_EN.
// Revision: 1.0
// ------------------------------------------------------------------------
module enc_cnt_capture #(
   parameter int         P_DEPTH   = 16,
   parameter logic [7:0] P_HDR_TAG = 8'hA5
) (
   input  logic                      CLK,
   input  logic                      I_RST_N,
   input  logic                      I_ARM,
   input  logic                      I_STB0,
   input  logic [63:0]               I_CNT0,
   input  logic                      I_STB1,
   input  logic [63:0]               I_CNT1,
   output logic [31:0]               O_TDATA,
   output logic                      O_TVALID,
   input  logic                      I_TREADY,
   output logic                      O_TLAST,
   output logic                      O_OVF,
   output logic [$clog2(P_DEPTH):0]  O_LEVEL
);
   localparam int AW = $clog2(P_DEPTH);
   localparam logic [AW:0] FULL_LVL = P_DEPTH[AW:0];
`ifdef ENC_CAP_TIMESTAMP_EN
   localparam int   REC_W   = 145;
   localparam logic TS_FLAG = 1'b1;
`else
   localparam int   REC_W   = 81;
   localparam logic TS_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_THI, S_TLO, S_CHI, S_CLO} state_t;

   logic [1:0]       stb_q, stb_d, rise, pend_v_q, pend_v_d;
   logic             arm_q, arm_d, arm_rise, ovf_q, ovf_d;
   logic [15:0]      seq_q [2];
   logic [15:0]      seq_d [2];
   logic [REC_W-1:0] pend_q [2];
   logic [REC_W-1:0] pend_d [2];
   logic [REC_W-1:0] mem_q [P_DEPTH];
   logic [REC_W-1:0] wr_rec, rd_rec;
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
   logic             full, empty, fifo_wr, fifo_rd, hs;
   state_t           state_q;
   logic [31:0]      tdata_q;
   logic             tvalid_q, tlast_q;
   logic [63:0]      cnt_hold_q;

`ifdef ENC_CAP_TIMESTAMP_EN
   logic [63:0] ts_q, ts_d, ts_hold_q;
   assign ts_d = ts_q + 64'd1;
   always_ff @(posedge CLK or negedge I_RST_N) begin
      if (!I_RST_N) ts_q <= '0;
      else          ts_q <= ts_d;
   end
`endif

   function automatic logic [31:0] hdr_word(input logic [16:0] ch_seq);
      return {P_HDR_TAG, 6'b0, TS_FLAG, ch_seq};
   endfunction

   always_comb begin
      stb_d    = {I_STB1, I_STB0};
      arm_d    = I_ARM;
      rise     = stb_d & ~stb_q;
      arm_rise = I_ARM & ~arm_q;
      level    = wr_ptr_q - rd_ptr_q;
      full     = (level == FULL_LVL);
      empty    = (level == '0);
      hs       = tvalid_q & I_TREADY;
      // channel 0 always wins the single write port
      fifo_wr  = (pend_v_q != 2'b00) && !full;
      wr_rec   = pend_v_q[0] ? pend_q[0] : pend_q[1];
      fifo_rd  = ((state_q == S_IDLE) || ((state_q == S_CLO) && hs)) && !empty;
      pend_v_d = pend_v_q;
      if (fifo_wr) begin
         if (pend_v_q[0]) pend_v_d[0] = 1'b0;
         else             pend_v_d[1] = 1'b0;
      end
      ovf_d = ovf_q & ~arm_rise;
      for (int i = 0; i < 2; i++) begin
         seq_d[i]  = arm_rise ? 16'd0 : seq_q[i];
         pend_d[i] = pend_q[i];
         if (I_ARM && rise[i]) begin
            // an occupied slot drops the event, even if it drains on this edge
            if (pend_v_q[i]) begin
               ovf_d = 1'b1;
            end else begin
`ifdef ENC_CAP_TIMESTAMP_EN
               pend_d[i] = {ts_q, 1'(i), seq_d[i], (i == 0) ? I_CNT0 : I_CNT1};
`else
               pend_d[i] = {1'(i), seq_d[i], (i == 0) ? I_CNT0 : I_CNT1};
`endif
               pend_v_d[i] = 1'b1;
            end
            seq_d[i] = seq_d[i] + 16'd1;
         end
      end
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_wr};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, fifo_rd};
   end

   always_ff @(posedge CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         stb_q    <= '0;
         arm_q    <= 1'b0;
         ovf_q    <= 1'b0;
         pend_v_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < 2; i++) begin
            seq_q[i]  <= '0;
            pend_q[i] <= '0;
         end
      end else begin
         stb_q    <= stb_d;
         arm_q    <= arm_d;
         ovf_q    <= ovf_d;
         pend_v_q <= pend_v_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         for (int i = 0; i < 2; i++) begin
            seq_q[i]  <= seq_d[i];
            pend_q[i] <= pend_d[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
   end
   assign rd_rec = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_q    <= S_IDLE;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         cnt_hold_q <= '0;
`ifdef ENC_CAP_TIMESTAMP_EN
         ts_hold_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (fifo_rd) begin
               cnt_hold_q <= rd_rec[63:0];
`ifdef ENC_CAP_TIMESTAMP_EN
               ts_hold_q  <= rd_rec[144:81];
`endif
               tdata_q    <= hdr_word(rd_rec[80:64]);
               tvalid_q   <= 1'b1;
               state_q    <= S_HDR;
            end
`ifdef ENC_CAP_TIMESTAMP_EN
            S_HDR: if (hs) begin
               tdata_q <= ts_hold_q[63:32];
               state_q <= S_THI;
            end
            S_THI: if (hs) begin
               tdata_q <= ts_hold_q[31:0];
               state_q <= S_TLO;
            end
            S_TLO: if (hs) begin
               tdata_q <= cnt_hold_q[63:32];
               state_q <= S_CHI;
            end
`else
            S_HDR: if (hs) begin
               tdata_q <= cnt_hold_q[63:32];
               state_q <= S_CHI;
            end
`endif
            S_CHI: if (hs) begin
               tdata_q <= cnt_hold_q[31:0];
               tlast_q <= 1'b1;
               state_q <= S_CLO;
            end
            S_CLO: if (hs) begin
               tlast_q <= 1'b0;
               if (fifo_rd) begin
                  cnt_hold_q <= rd_rec[63:0];
`ifdef ENC_CAP_TIMESTAMP_EN
                  ts_hold_q  <= rd_rec[144:81];
`endif
                  tdata_q    <= hdr_word(rd_rec[80:64]);
                  state_q    <= S_HDR;
               end else begin
                  tdata_q  <= '0;
                  tvalid_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign O_TDATA  = tdata_q;
   assign O_TVALID = tvalid_q;
   assign O_TLAST  = tlast_q;
   assign O_OVF    = ovf_q;
   assign O_LEVEL  = level;
endmodule
`default_nettype wire

// File: tb/tb_enc_cnt_capture.sv
`default_nettype none
// tb_enc_cnt_capture : randomized + directed bench with a word scoreboard.
module tb_enc_cnt_capture;
   logic        CLK = 1'b0;
   logic        I_RST_N = 1'b0;
   logic        I_ARM = 1'b0;
   logic        I_STB0 = 1'b0, I_STB1 = 1'b0;
   logic [63:0] I_CNT0 = '0, I_CNT1 = '0;
   logic [31:0] O_TDATA;
   logic        O_TVALID, O_TLAST, O_OVF;
   logic        I_TREADY = 1'b0;
   logic [4:0]  O_LEVEL;

   enc_cnt_capture #(.P_DEPTH(16), .P_HDR_TAG(8'hA5)) dut (
      .CLK(CLK), .I_RST_N(I_RST_N), .I_ARM(I_ARM),
      .I_STB0(I_STB0), .I_CNT0(I_CNT0), .I_STB1(I_STB1), .I_CNT1(I_CNT1),
      .O_TDATA(O_TDATA), .O_TVALID(O_TVALID), .I_TREADY(I_TREADY),
      .O_TLAST(O_TLAST), .O_OVF(O_OVF), .O_LEVEL(O_LEVEL));

   always #5 CLK = ~CLK;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];        // {last, data}
   logic [15:0] seq_m [2];
   bit          arm_m = 0;
   bit          bp_mode = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK); #1;
      if (bp_mode) I_TREADY = ($urandom_range(0, 9) < 6);
   endtask

   task automatic push_rec(input bit ch, input logic [63:0] cnt);
      exp_q.push_back({1'b0, 8'hA5, 6'b0, 1'b0, ch, seq_m[ch]});
      exp_q.push_back({1'b0, cnt[63:32]});
      exp_q.push_back({1'b1, cnt[31:0]});
   endtask

   // Reference: an armed rising edge consumes a sequence number; accepted
   // events are queued with channel 0 ahead of channel 1 on a tie.
   task automatic pulse(input bit s0, input bit s1, input logic [63:0] c0,
                        input logic [63:0] c1, input bit acc, input int hold);
      I_STB0 = s0; I_STB1 = s1; I_CNT0 = c0; I_CNT1 = c1;
      if (arm_m) begin
         if (s0) begin if (acc) push_rec(1'b0, c0); seq_m[0]++; end
         if (s1) begin if (acc) push_rec(1'b1, c1); seq_m[1]++; end
      end
      for (int k = 0; k < hold; k++) tick();
      I_STB0 = 1'b0; I_STB1 = 1'b0;
   endtask

   task automatic set_arm(input bit v);
      if (v && !arm_m) begin seq_m[0] = 0; seq_m[1] = 0; end
      arm_m = v; I_ARM = v;
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || O_TVALID) && n < 3000) begin tick(); n++; end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_drain: %0d words still expected after timeout, need 0", nm, exp_q.size());
      end
      idle(8);
   endtask

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   logic [31:0] prev_data;
   logic        prev_last, prev_stall = 1'b0;
   always @(negedge CLK) begin
      if (!I_RST_N) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!O_TVALID || O_TDATA !== prev_data || O_TLAST !== prev_last) begin
               errors++;
               $display("FAIL stall_stable: got v=%b d=%h l=%b need v=1 d=%h l=%b",
                        O_TVALID, O_TDATA, O_TLAST, prev_data, prev_last);
            end
         end
         if (O_TVALID && I_TREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got d=%h l=%b need no word", O_TDATA, O_TLAST);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               if ({O_TLAST, O_TDATA} !== e) begin
                  errors++;
                  $display("FAIL word: got l=%b d=%h need l=%b d=%h", O_TLAST, O_TDATA, e[32], e[31:0]);
               end
            end
         end
         prev_stall = O_TVALID && !I_TREADY;
         prev_data  = O_TDATA;
         prev_last  = O_TLAST;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int peak, recs;
      seq_m[0] = 0; seq_m[1] = 0;
      // reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tvalid", O_TVALID, 0); chk("rst_tlast", O_TLAST, 0);
      chk("rst_tdata", O_TDATA, 0);   chk("rst_ovf", O_OVF, 0);
      chk("rst_level", O_LEVEL, 0);
      I_RST_N = 1'b1;
      tick();

      // single event, latency and word format
      I_TREADY = 1'b1;
      set_arm(1);
      pulse(1, 0, 64'h0000_0001_0000_0005, 0, 1, 1);
      chk("lat_n_valid", O_TVALID, 0);
      tick();
      chk("lat_n1_valid", O_TVALID, 0);
      chk("lat_n1_level", O_LEVEL, 1);
      tick();
      chk("lat_n2_valid", O_TVALID, 1);
      chk("lat_n2_hdr", O_TDATA, 32'hA500_0000);
      drain("single");
      chk("single_ovf", O_OVF, 0);

      // simultaneous edges on both channels
      set_arm(0); set_arm(1);
      pulse(1, 1, 64'd10, 64'd20, 1, 1);
      peak = 0;
      for (int k = 0; k < 12; k++) begin
         if (int'(O_LEVEL) > peak) peak = int'(O_LEVEL);
         tick();
      end
      chk("sim_peak_1_or_2", (peak >= 1 && peak <= 2), 1);
      drain("simul");
      chk("simul_ovf", O_OVF, 0);

      // overflow: serialiser + 16 FIFO + 1 slot hold 18 records, rest drop
      set_arm(0); set_arm(1);
      I_TREADY = 1'b0;
      for (int k = 0; k < 20; k++) begin
         pulse(1, 0, 64'h100 + 64'(k), 0, (k < 18), 1);
         idle(3);
      end
      chk("full_level", O_LEVEL, 16);
      chk("full_ovf", O_OVF, 1);
      I_TREADY = 1'b1;
      drain("full");
      chk("full_level_empty", O_LEVEL, 0);
      chk("full_ovf_sticky", O_OVF, 1);
      pulse(1, 0, 64'hDEAD, 0, 1, 1);   // shows the seq gap (seq 20)
      drain("gap");

      // random backpressure, 100 records
      set_arm(0); set_arm(1);
      tick();
      chk("rearm_ovf_clear", O_OVF, 0);
      bp_mode = 1;
      recs = 0;
      while (recs < 100) begin
         int sel;
         sel = $urandom_range(0, 2);
         pulse(sel != 1, sel != 0, {$urandom, $urandom}, {$urandom, $urandom}, 1,
               $urandom_range(1, 3));
         recs += (sel == 2) ? 2 : 1;
         idle(20);
      end
      drain("random");
      bp_mode = 0;
      chk("random_ovf", O_OVF, 0);

      // disarm with records queued, then re-arm
      I_TREADY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pulse(1, 0, 64'h3000 + 64'(k), 0, 1, 1);
         idle(3);
      end
      set_arm(0);
      pulse(1, 1, 64'h77, 64'h88, 1, 1);
      idle(3);
      I_TREADY = 1'b1;
      drain("disarm");
      set_arm(1);
      tick();
      chk("rearm2_ovf", O_OVF, 0);
      pulse(0, 1, 0, 64'hABCD_0123_4567_89EF, 1, 1);
      drain("rearm");

      // reset in the middle of a record
      pulse(1, 0, 64'h1111_2222_3333_4444, 0, 1, 1);
      begin
         int n = 0;
         while (!O_TVALID && n < 20) begin tick(); n++; end
      end
      chk("mid_hdr_valid", O_TVALID, 1);
      tick();
      I_TREADY = 1'b0;
      chk("mid_chi_word", O_TDATA, 32'h1111_2222);
      I_RST_N = 1'b0;
      #1;
      chk("mid_rst_tvalid", O_TVALID, 0); chk("mid_rst_tdata", O_TDATA, 0);
      chk("mid_rst_tlast", O_TLAST, 0);   chk("mid_rst_level", O_LEVEL, 0);
      exp_q.delete();
      seq_m[0] = 0; seq_m[1] = 0;
      tick(); tick();
      I_RST_N = 1'b1;
      I_TREADY = 1'b1;
      idle(6);
      chk("post_rst_idle", O_TVALID, 0);
      pulse(1, 0, 64'h5555_6666_7777_8888, 0, 1, 1);
      drain("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
